// File: rtl/ram_arbiter.sv
// Round-robin share of one write-first 1-cycle RAM between fetch (port 0) and LSU (port 1); sub-word stores via RMW.
// Latency accept->rsp: 1 cycle (read/full write), 2 cycles (partial write); no rsp backpressure, ready only in IDLE.
module ram_arbiter #(
    parameter  int DEPTH      = 2**16,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = $clog2(DEPTH),
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_we,
    input  logic [AW-1:0]         i_req0_addr,
    input  logic [BW-1:0]         i_req0_be,
    input  logic [DATA_WIDTH-1:0] i_req0_wdata,
    output logic                  o_rsp0_valid,
    output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_we,
    input  logic [AW-1:0]         i_req1_addr,
    input  logic [BW-1:0]         i_req1_be,
    input  logic [DATA_WIDTH-1:0] i_req1_wdata,
    output logic                  o_rsp1_valid,
    output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [AW-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {IDLE, RESP, MERGE} state_t;

    state_t                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  gnt_q, gnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BW-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  any_vld;
    logic                  gnt_c;
    logic                  req_we;
    logic [AW-1:0]         req_addr;
    logic [BW-1:0]         req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] merged;

    // Tie goes to rr_ptr; otherwise the single valid port wins.
    assign any_vld   = i_req0_valid | i_req1_valid;
    assign gnt_c     = (i_req0_valid & i_req1_valid) ? rr_ptr_q : i_req1_valid;
    assign req_we    = gnt_c ? i_req1_we    : i_req0_we;
    assign req_addr  = gnt_c ? i_req1_addr  : i_req0_addr;
    assign req_be    = gnt_c ? i_req1_be    : i_req0_be;
    assign req_wdata = gnt_c ? i_req1_wdata : i_req0_wdata;

    always_comb begin
        merged = '0;
        for (int k = 0; k < BW; k++) begin
            merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : i_ram_rdata[8*k +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        o_rsp0_rdata = '0;
        o_rsp1_rdata = '0;
        o_ram_en     = 1'b0;
        o_ram_we     = 1'b0;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    o_req0_ready = ~gnt_c;
                    o_req1_ready = gnt_c;
                    rr_ptr_d     = ~gnt_c;
                    gnt_d        = gnt_c;
                    addr_d       = req_addr;
                    be_d         = req_be;
                    wdata_d      = req_wdata;
                    o_ram_en     = 1'b1;
                    o_ram_addr   = req_addr;
                    if (req_we && (&req_be)) begin
                        o_ram_we    = 1'b1;
                        o_ram_wdata = req_wdata;
                        state_d     = RESP;
                    end else if (req_we && (|req_be)) begin
                        // Fetch the old word; bytes are merged next cycle.
                        state_d = MERGE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            MERGE: begin
                o_ram_en    = 1'b1;
                o_ram_we    = 1'b1;
                o_ram_addr  = addr_q;
                o_ram_wdata = merged;
                state_d     = RESP;
            end
            RESP: begin
                // Write-first RAM returns the stored word for writes too.
                o_rsp0_valid = ~gnt_q;
                o_rsp1_valid = gnt_q;
                o_rsp0_rdata = gnt_q ? '0 : i_ram_rdata;
                o_rsp1_rdata = gnt_q ? i_ram_rdata : '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_rst) begin
            o_req0_ready = 1'b0;
            o_req1_ready = 1'b0;
            o_rsp0_valid = 1'b0;
            o_rsp1_valid = 1'b0;
            o_rsp0_rdata = '0;
            o_rsp1_rdata = '0;
            o_ram_en     = 1'b0;
            o_ram_we     = 1'b0;
            o_ram_addr   = '0;
            o_ram_wdata  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule
